// File: rtl/unary_acc_border_if.sv
// unary_acc_border_if: control, data and result handshake between the column
// driver (master) and the border accumulator (slave). ACCW must match the
// accumulator width of the unary_acc_border instance it connects to.
interface unary_acc_border_if #(
    parameter int ACCW = 16
);
    logic            init;
    logic            clr;
    logic [ACCW-1:0] i_psum;
    logic            i_bit;
    logic            i_sign;
    logic            i_ready;
    logic [ACCW-1:0] o_sum;
    logic            o_valid;
    logic            o_busy;

    modport master (
        output init, clr, i_psum, i_bit, i_sign, i_ready,
        input  o_sum, o_valid, o_busy
    );

    modport slave (
        input  init, clr, i_psum, i_bit, i_sign, i_ready,
        output o_sum, o_valid, o_busy
    );
endinterface

// File: rtl/unary_acc_border.sv
// unary_acc_border: counts a unary product bitstream over a 2^(WIDTH-1) cycle
// window into a signed accumulator preloaded with a partial sum, then offers
// the result on a valid/ready handshake.
// Optional macro SATURATE_EN: clamp the accumulator at the signed limits
// (sticky until the next load) instead of wrapping modulo 2^ACCW.
module unary_acc_border #(
    parameter int WIDTH = 8,
    parameter int ACCW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    unary_acc_border_if.slave     bus
);
    localparam int WB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state_q, state_d;
    logic [WB-1:0]   wcnt_q, wcnt_d;
    logic [ACCW-1:0] acc_q, acc_d, acc_step;
    logic [ACCW-1:0] sum_q, sum_d;
    logic            valid_q, valid_d;
    logic            busy_q;
    logic            inc, dec;

`ifdef SATURATE_EN
    localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
    logic sat_q, sat_d, sat_step;
`endif

    assign inc = bus.i_bit & ~bus.i_sign;
    assign dec = bus.i_bit &  bus.i_sign;

    // Next accumulator value for this cycle's product bit.
    always_comb begin
        acc_step = acc_q;
`ifdef SATURATE_EN
        sat_step = sat_q;
        if (!sat_q) begin
            if (inc) begin
                if (acc_q == ACC_MAX) sat_step = 1'b1;
                else                  acc_step = acc_q + 1'b1;
            end else if (dec) begin
                if (acc_q == ACC_MIN) sat_step = 1'b1;
                else                  acc_step = acc_q - 1'b1;
            end
        end
`else
        if (inc)      acc_step = acc_q + 1'b1;
        else if (dec) acc_step = acc_q - 1'b1;
`endif
    end

    // FSM next state and datapath updates; clr beats init beats normal flow.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        valid_d = valid_q;
`ifdef SATURATE_EN
        sat_d   = sat_q;
`endif
        if (bus.clr) begin
            state_d = IDLE;
            wcnt_d  = '0;
            acc_d   = '0;
            sum_d   = '0;
            valid_d = 1'b0;
`ifdef SATURATE_EN
            sat_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.init) begin
                        state_d = ACCUM;
                        wcnt_d  = '0;
                        acc_d   = bus.i_psum;
`ifdef SATURATE_EN
                        sat_d   = 1'b0;
`endif
                    end
                end
                ACCUM: begin
                    if (bus.init) begin
                        // restart: bits counted so far are dropped
                        wcnt_d  = '0;
                        acc_d   = bus.i_psum;
`ifdef SATURATE_EN
                        sat_d   = 1'b0;
`endif
                    end else begin
                        acc_d  = acc_step;
`ifdef SATURATE_EN
                        sat_d  = sat_step;
`endif
                        wcnt_d = wcnt_q + 1'b1;
                        if (&wcnt_q) begin
                            state_d = DONE;
                            sum_d   = acc_step;
                            valid_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // result is held until consumed; init only counts with i_ready
                    if (bus.i_ready) begin
                        valid_d = 1'b0;
                        if (bus.init) begin
                            state_d = ACCUM;
                            wcnt_d  = '0;
                            acc_d   = bus.i_psum;
`ifdef SATURATE_EN
                            sat_d   = 1'b0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            busy_q  <= (state_d == ACCUM);
`ifdef SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign bus.o_sum   = sum_q;
    assign bus.o_valid = valid_q;
    assign bus.o_busy  = busy_q;
endmodule

// File: tb/tb_unary_acc_border.sv
// tb_unary_acc_border: directed scoreboard bench; a 16-bit accumulator for the
// functional cases and an 8-bit one for the overflow cases.
module tb_unary_acc_border;
    localparam int N = 128;

    logic clk = 1'b0;
    logic rst;
    logic init, clr, i_bit, i_sign, i_ready, sel8;
    logic [15:0] psum;
    logic [15:0] obs_sum;
    logic        obs_valid, obs_busy;

    logic [15:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    unary_acc_border_if #(.ACCW(16)) bus  ();
    unary_acc_border_if #(.ACCW(8))  bus8 ();

    unary_acc_border #(.WIDTH(8), .ACCW(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    unary_acc_border #(.WIDTH(8), .ACCW(8))  u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    assign bus.init     = init & ~sel8;
    assign bus.clr      = clr;
    assign bus.i_psum   = psum;
    assign bus.i_bit    = i_bit;
    assign bus.i_sign   = i_sign;
    assign bus.i_ready  = i_ready;
    assign bus8.init    = init & sel8;
    assign bus8.clr     = clr;
    assign bus8.i_psum  = psum[7:0];
    assign bus8.i_bit   = i_bit;
    assign bus8.i_sign  = i_sign;
    assign bus8.i_ready = i_ready;

    assign obs_sum   = sel8 ? {{8{bus8.o_sum[7]}}, bus8.o_sum} : bus.o_sum;
    assign obs_valid = sel8 ? bus8.o_valid : bus.o_valid;
    assign obs_busy  = sel8 ? bus8.o_busy  : bus.o_busy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // pulse init for one edge and record the result this window must produce
    task automatic start(input logic [15:0] p, input logic [15:0] expv);
        init = 1'b1;
        psum = p;
        exp_q.push_back(expv);
        tick();
        init = 1'b0;
    endtask

    // drive one full window: 'ones' leading ones, then zeros
    task automatic run_bits(input string tag, input int ones, input logic sgn);
        for (int k = 0; k < N; k++) begin
            i_bit  = (k < ones);
            i_sign = sgn;
            if (k == 0)     check({tag, "_busy"}, obs_busy, 1);
            if (k == N - 1) check({tag, "_early"}, obs_valid, 0);
            tick();
        end
        i_bit  = 1'b0;
        i_sign = 1'b0;
    endtask

    // wait (bounded) for o_valid, then compare against the scoreboard head
    task automatic collect(input string tag, input int max_cyc, input int exp_wait);
        int c = 0;
        logic [15:0] e;
        while (!obs_valid && c < max_cyc) begin
            tick();
            c++;
        end
        check({tag, "_lat"}, c, exp_wait);
        check({tag, "_valid"}, obs_valid, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, obs_sum, e);
        end
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; clr = 1'b0; i_bit = 1'b0; i_sign = 1'b0;
        i_ready = 1'b1; sel8 = 1'b0; psum = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_sum", obs_sum, 0);
        check("rst_valid", obs_valid, 0);
        check("rst_busy", obs_busy, 0);

        // full-count window
        start(16'd0, 16'd128);
        run_bits("full", 128, 1'b0);
        collect("full", 4, 0);
        tick();
        check("full_idle_valid", obs_valid, 0);
        check("full_idle_busy", obs_busy, 0);

        // signed subtraction
        start(16'd100, 16'd50);
        run_bits("sub", 50, 1'b1);
        collect("sub", 4, 0);
        tick();

        // backpressure: result held, init ignored while stalled
        i_ready = 1'b0;
        start(16'd3, 16'd131);
        run_bits("bp", 128, 1'b0);
        collect("bp", 4, 0);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin init = 1'b1; psum = 16'd7; end
            else        init = 1'b0;
            tick();
            check("bp_hold_valid", obs_valid, 1);
            check("bp_hold_sum", obs_sum, 131);
        end
        check("bp_init_ignored", obs_busy, 0);
        i_ready = 1'b1;
        start(16'd7, 16'd27);
        check("bp_restart_busy", obs_busy, 1);
        check("bp_restart_valid", obs_valid, 0);
        run_bits("bp2", 20, 1'b0);
        collect("bp2", 4, 0);
        tick();

        // abort mid-window
        init = 1'b1; psum = 16'd77; tick(); init = 1'b0;
        for (int k = 0; k < 60; k++) begin i_bit = 1'b1; tick(); end
        i_bit = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_busy", obs_busy, 0);
        check("clr_valid", obs_valid, 0);
        for (int k = 0; k < 140; k++) tick();
        check("clr_no_valid", obs_valid, 0);
        start(16'd5, 16'd15);
        run_bits("fresh", 10, 1'b0);
        collect("fresh", 4, 0);
        tick();

        // restart by init at window cycle 40
        init = 1'b1; psum = 16'd9; tick(); init = 1'b0;
        for (int k = 0; k < 40; k++) begin i_bit = 1'b1; tick(); end
        i_bit = 1'b0;
        start(16'd2, 16'd66);
        run_bits("restart", 64, 1'b0);
        collect("restart", 4, 0);
        tick();

        // overflow on the 8-bit accumulator
        sel8 = 1'b1;
`ifdef SATURATE_EN
        start(16'd100, 16'h007F);
`else
        start(16'd100, 16'hFFE4);
`endif
        run_bits("ovf_pos", 128, 1'b0);
        collect("ovf_pos", 4, 0);
        tick();
`ifdef SATURATE_EN
        start(16'hFF9C, 16'hFF80);
`else
        start(16'hFF9C, 16'h001C);
`endif
        run_bits("ovf_neg", 128, 1'b1);
        collect("ovf_neg", 4, 0);
        tick();
        sel8 = 1'b0;

        // synchronous reset at window cycle 70
        init = 1'b1; psum = 16'd55; tick(); init = 1'b0;
        for (int k = 0; k < 70; k++) begin i_bit = 1'b1; tick(); end
        i_bit = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_sum", obs_sum, 0);
        check("mrst_valid", obs_valid, 0);
        check("mrst_busy", obs_busy, 0);
        start(16'd1, 16'd129);
        run_bits("post_rst", 128, 1'b0);
        collect("post_rst", 4, 0);
        tick();

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
